// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access and register writeback stage.
// Accepts one operation at a time from the controller: ALU writeback, word load,
// word store or nop. Loads and stores run a req/gnt/rvalid handshake with data
// memory, and results are driven onto the register-file write port. All outputs
// are registered.
// Optional feature: define MEM_TMO_EN to abort a memory transaction that spends
// TMO_CYCLES cycles in REQ/WAIT without completing. err_timeout pulses on abort.
module mem_wb_stage #(
    parameter int unsigned DWIDTH     = 32,
    parameter int unsigned RWIDTH     = 6,
    parameter int unsigned TMO_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [RWIDTH-1:0] in_rd,
    input  logic [DWIDTH-1:0] in_alu,
    input  logic [DWIDTH-1:0] in_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              wb_we,
    output logic [RWIDTH-1:0] wb_wa,
    output logic [DWIDTH-1:0] wb_wd,
    output logic              store_done,
    output logic              err_misalign,
    output logic              err_timeout
);

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_WB
    } state_t;

    // The abort counter needs at least two states to be meaningful.
    if (TMO_CYCLES < 2) begin : g_bad_tmo
        $error("mem_wb_stage: TMO_CYCLES must be at least 2");
    end

    state_t state, state_nxt;

    // Captured operands of the operation in flight.
    logic [1:0]        cap_op,    cap_op_nxt;
    logic [RWIDTH-1:0] cap_rd,    cap_rd_nxt;
    logic [DWIDTH-1:0] cap_alu,   cap_alu_nxt;
    logic [DWIDTH-1:0] cap_wdata, cap_wdata_nxt;

    // Registered output state.
    logic              rdy_q,  rdy_nxt;
    logic              req_q,  req_nxt;
    logic              mwe_q,  mwe_nxt;
    logic              wbwe_q, wbwe_nxt;
    logic [RWIDTH-1:0] wa_q,   wa_nxt;
    logic [DWIDTH-1:0] wd_q,   wd_nxt;
    logic              sd_q,   sd_nxt;
    logic              mis_q,  mis_nxt;

`ifdef MEM_TMO_EN
    localparam int unsigned CNT_W = $clog2(TMO_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TMO_CYCLES - 1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             tmo_q, tmo_nxt;
    logic             expired;

    // Counter at or past the limit; >= so a grant on the last REQ cycle still
    // aborts on the first WAIT cycle without rvalid.
    assign expired = (cnt >= CNT_LIMIT);
`endif

    // State, captured operands and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cap_op    <= '0;
            cap_rd    <= '0;
            cap_alu   <= '0;
            cap_wdata <= '0;
            rdy_q     <= 1'b1;
            req_q     <= 1'b0;
            mwe_q     <= 1'b0;
            wbwe_q    <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
            sd_q      <= 1'b0;
            mis_q     <= 1'b0;
`ifdef MEM_TMO_EN
            cnt       <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cap_op    <= cap_op_nxt;
            cap_rd    <= cap_rd_nxt;
            cap_alu   <= cap_alu_nxt;
            cap_wdata <= cap_wdata_nxt;
            rdy_q     <= rdy_nxt;
            req_q     <= req_nxt;
            mwe_q     <= mwe_nxt;
            wbwe_q    <= wbwe_nxt;
            wa_q      <= wa_nxt;
            wd_q      <= wd_nxt;
            sd_q      <= sd_nxt;
            mis_q     <= mis_nxt;
`ifdef MEM_TMO_EN
            cnt       <= cnt_nxt;
            tmo_q     <= tmo_nxt;
`endif
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt     = state;
        cap_op_nxt    = cap_op;
        cap_rd_nxt    = cap_rd;
        cap_alu_nxt   = cap_alu;
        cap_wdata_nxt = cap_wdata;
        req_nxt       = 1'b0;
        mwe_nxt       = 1'b0;
        wbwe_nxt      = 1'b0;
        wa_nxt        = wa_q;
        wd_nxt        = wd_q;
        sd_nxt        = 1'b0;
        mis_nxt       = 1'b0;
`ifdef MEM_TMO_EN
        cnt_nxt       = cnt;
        tmo_nxt       = 1'b0;
`endif

        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    cap_op_nxt    = in_op;
                    cap_rd_nxt    = in_rd;
                    cap_alu_nxt   = in_alu;
                    cap_wdata_nxt = in_wdata;
                    case (in_op)
                        OP_ALU: begin
                            state_nxt = S_WB;
                            wbwe_nxt  = 1'b1;
                            wa_nxt    = in_rd;
                            wd_nxt    = in_alu;
                        end
                        OP_LOAD, OP_STORE: begin
                            if (in_alu[1:0] != 2'b00) begin
                                mis_nxt = 1'b1;
                            end else begin
                                state_nxt = S_REQ;
                                req_nxt   = 1'b1;
                                mwe_nxt   = (in_op == OP_STORE);
`ifdef MEM_TMO_EN
                                cnt_nxt   = '0;
`endif
                            end
                        end
                        default: ;  // nop: accepted, no side effects
                    endcase
                end
            end

            S_REQ: begin
                if (mem_gnt) begin
                    if (cap_op == OP_STORE) begin
                        state_nxt = S_IDLE;
                        sd_nxt    = 1'b1;
                    end else if (mem_rvalid) begin
                        state_nxt = S_WB;
                        wbwe_nxt  = 1'b1;
                        wa_nxt    = cap_rd;
                        wd_nxt    = mem_rdata;
                    end else begin
                        state_nxt = S_WAIT;
`ifdef MEM_TMO_EN
                        cnt_nxt   = cnt + 1'b1;
`endif
                    end
                end else begin
                    req_nxt = 1'b1;
                    mwe_nxt = mwe_q;
`ifdef MEM_TMO_EN
                    if (expired) begin
                        state_nxt = S_IDLE;
                        req_nxt   = 1'b0;
                        mwe_nxt   = 1'b0;
                        tmo_nxt   = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                    end
`endif
                end
            end

            S_WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = S_WB;
                    wbwe_nxt  = 1'b1;
                    wa_nxt    = cap_rd;
                    wd_nxt    = mem_rdata;
                end else begin
`ifdef MEM_TMO_EN
                    if (expired) begin
                        state_nxt = S_IDLE;
                        tmo_nxt   = 1'b1;
                    end else begin
                        cnt_nxt   = cnt + 1'b1;
                    end
`endif
                end
            end

            S_WB: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        rdy_nxt = (state_nxt == S_IDLE);
    end

    assign in_ready     = rdy_q;
    assign mem_req      = req_q;
    assign mem_we       = mwe_q;
    assign mem_addr     = cap_alu;
    assign mem_wdata    = cap_wdata;
    assign wb_we        = wbwe_q;
    assign wb_wa        = wa_q;
    assign wb_wd        = wd_q;
    assign store_done   = sd_q;
    assign err_misalign = mis_q;
`ifdef MEM_TMO_EN
    assign err_timeout  = tmo_q;
`else
    assign err_timeout  = 1'b0;
`endif

endmodule
